// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: rising-edge ticks from a slow clock level driving a double-buffered PWM
module pwm_tick_gen #(
    parameter int CNT_W   = 8,
    parameter bit RST_PWM = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_slow_clk,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pwm,
    output logic             o_tick,
    output logic             o_period_done,
    output logic             o_busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt, p_act, d_act, p_sh, d_sh;
    logic             pend, prev_slow, period_done;
    logic             tick, busy, boundary;
    assign tick          = i_slow_clk & ~prev_slow;
    assign busy          = state != IDLE;
    assign boundary      = tick & busy & (cnt == p_act);
    assign o_tick        = tick;
    assign o_busy        = busy;
    assign o_period_done = period_done;
    assign o_pwm         = busy ? (cnt < d_act) : RST_PWM;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            p_act       <= '0;
            d_act       <= '0;
            p_sh        <= '0;
            d_sh        <= '0;
            pend        <= 1'b0;
            prev_slow   <= 1'b1;
            period_done <= 1'b0;
        end else begin
            prev_slow   <= i_slow_clk;
            period_done <= boundary;
            cnt         <= !busy ? '0 : tick ? ((cnt == p_act) ? '0 : cnt + 1'b1) : cnt;
            // a load landing on the boundary goes straight to the active registers
            if (boundary && i_load) begin
                p_act <= i_period;
                d_act <= i_duty;
                pend  <= 1'b0;
            end else begin
                if (pend && (!busy || boundary)) begin
                    p_act <= p_sh;
                    d_act <= d_sh;
                    pend  <= 1'b0;
                end
                if (i_load) begin
                    p_sh <= i_period;
                    d_sh <= i_duty;
                    pend <= 1'b1;
                end
            end
            state <= i_en ? RUN : (state == RUN) ? DRAIN : (state == DRAIN && !boundary) ? DRAIN : IDLE;
        end
    end
endmodule

// File: tb/tb_pwm_tick_gen.sv
// tb_pwm_tick_gen: directed scenarios plus random traffic against a tick-level reference model
module tb_pwm_tick_gen;
    logic       clk = 1'b0, rst_n = 1'b0, slow = 1'b1, en = 1'b0, load = 1'b0;
    logic [7:0] period = '0, duty = '0;
    logic       o_pwm, o_tick, o_period_done, o_busy;
    int         vecs = 0, errs = 0, ph = 0;
    int         m_mode;
    logic [7:0] m_cnt, m_p, m_d, m_sp, m_sd;
    logic       m_pend, m_prev, m_done;

    pwm_tick_gen #(.CNT_W(8), .RST_PWM(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_slow_clk(slow), .i_en(en), .i_load(load),
        .i_period(period), .i_duty(duty), .o_pwm(o_pwm), .o_tick(o_tick),
        .o_period_done(o_period_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // mode: 0 idle, 1 running, 2 draining until the period ends
    function automatic void model();
        logic tk, bnd;
        int   nxt;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_p = 0; m_d = 0; m_sp = 0; m_sd = 0;
            m_pend = 0; m_prev = 1; m_done = 0;
            return;
        end
        tk  = slow && !m_prev;
        bnd = tk && m_mode != 0 && m_cnt == m_p;
        if (en) nxt = 1;
        else if (m_mode == 1) nxt = 2;
        else if (m_mode == 2 && !bnd) nxt = 2;
        else nxt = 0;
        if (m_mode == 0) m_cnt = 0;
        else if (tk) m_cnt = 8'((int'(m_cnt) + 1) % (int'(m_p) + 1));
        if (bnd && load) begin
            m_p = period; m_d = duty; m_pend = 0;
        end else begin
            if (m_pend && (m_mode == 0 || bnd)) begin
                m_p = m_sp; m_d = m_sd; m_pend = 0;
            end
            if (load) begin
                m_sp = period; m_sd = duty; m_pend = 1;
            end
        end
        m_done = bnd;
        m_prev = slow;
        m_mode = nxt;
    endfunction

    function automatic logic [3:0] expv();
        logic pwm;
        pwm = (m_mode == 0) ? 1'b0 : (m_cnt < m_d);
        return {pwm, slow & ~m_prev, m_done, m_mode != 0};
    endfunction

    task automatic step();
        @(posedge clk);
        model();
        @(negedge clk);
        ph++;
    endtask

    task automatic test_reset();
        rst_n = 0; slow = 1;
        step(); step();
        #1;
        vecs++;
        if ({o_pwm, o_tick, o_period_done, o_busy} !== 4'b0000) begin
            errs++; $display("FAIL reset_outputs got %b want 0000", {o_pwm, o_tick, o_period_done, o_busy});
        end
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            slow = (i < 3) ? 1'b1 : (i == 3) ? 1'b0 : 1'b1;
            #1;
            vecs++;
            if (o_tick !== (i == 4)) begin
                errs++; $display("FAIL reset_tick cyc %0d got %b want %b", i, o_tick, i == 4);
            end
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv()) begin
                errs++; $display("FAIL reset_model cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            step();
        end
    endtask

    task automatic test_basic();
        int highs = 0, dones = 0;
        load = 1; period = 3; duty = 2; slow = ph[2];
        step();
        load = 0; en = 1;
        for (int i = 0; i < 192; i++) begin
            slow = ph[2];
            #1;
            if (i >= 64) begin
                highs += int'(o_pwm);
                dones += int'(o_period_done);
            end
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv()) begin
                errs++; $display("FAIL basic cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            step();
        end
        vecs++;
        if (highs != 64) begin errs++; $display("FAIL basic_high_cycles got %0d want 64", highs); end
        vecs++;
        if (dones != 4) begin errs++; $display("FAIL basic_done_pulses got %0d want 4", dones); end
    endtask

    task automatic test_reload();
        int highs = 0;
        for (int i = 0; i < 160; i++) begin
            slow = ph[2];
            load = (i == 12);
            period = 1; duty = 1;
            #1;
            if (i >= 96) highs += int'(o_pwm);
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv()) begin
                errs++; $display("FAIL reload cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            step();
        end
        load = 0;
        vecs++;
        if (highs != 32) begin errs++; $display("FAIL reload_high_cycles got %0d want 32", highs); end
    endtask

    task automatic test_duty_corners();
        logic [7:0] cp[3] = '{8'd4, 8'd4, 8'd0};
        logic [7:0] cd[3] = '{8'd0, 8'd5, 8'd1};
        logic       cv[3] = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            int dones = 0;
            en = 0;
            for (int i = 0; i < 200 && m_mode != 0; i++) begin
                slow = ph[2];
                step();
            end
            vecs++;
            if (m_mode != 0 || o_busy !== 1'b0) begin errs++; $display("FAIL corner_stop %0d got busy %b want 0", k, o_busy); end
            load = 1; period = cp[k]; duty = cd[k]; slow = ph[2];
            step();
            load = 0; en = 1;
            for (int i = 0; i < 80; i++) begin
                slow = ph[2];
                #1;
                if (i >= 16) dones += int'(o_period_done);
                vecs++;
                if ({o_pwm, o_tick, o_period_done, o_busy} !== expv() || (o_busy && o_pwm !== cv[k])) begin
                    errs++; $display("FAIL corner %0d cyc %0d got %b want %b", k, i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
                end
                step();
            end
            if (k == 2) begin
                vecs++;
                if (dones != 8) begin errs++; $display("FAIL corner_p0_dones got %0d want 8", dones); end
            end
        end
    endtask

    task automatic test_drain();
        logic fell = 0;
        load = 1; period = 3; duty = 2; slow = ph[2];
        step();
        load = 0;
        for (int i = 0; i < 300 && !(m_p == 3 && m_cnt == 1); i++) begin
            slow = ph[2];
            step();
        end
        vecs++;
        if (!(m_p == 3 && m_cnt == 1)) begin errs++; $display("FAIL drain_wait got cnt %0d want 1", m_cnt); end
        en = 0;
        for (int i = 0; i < 100 && !fell; i++) begin
            slow = ph[2];
            #1;
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv()) begin
                errs++; $display("FAIL drain cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            if (!o_busy) begin
                fell = 1;
                vecs++;
                if ({o_pwm, o_period_done} !== 2'b01) begin
                    errs++; $display("FAIL drain_end got pwm/done %b want 01", {o_pwm, o_period_done});
                end
            end
            step();
        end
        vecs++;
        if (!fell) begin errs++; $display("FAIL drain_timeout got busy 1 want 0"); end
        en = 1;
        for (int i = 0; i < 100 && m_cnt != 1; i++) begin slow = ph[2]; step(); end
        en = 0;
        for (int i = 0; i < 100 && m_cnt != 2; i++) begin slow = ph[2]; step(); end
        en = 1;
        for (int i = 0; i < 64; i++) begin
            slow = ph[2];
            #1;
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv() || o_busy !== 1'b1) begin
                errs++; $display("FAIL drain_resume cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            step();
        end
    endtask

    task automatic test_load_boundary_reset();
        logic hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            slow = ph[2];
            hit = slow && !m_prev && m_mode != 0 && m_cnt == m_p && m_p == 3;
            load = hit; period = 2; duty = 1;
            #1;
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv()) begin
                errs++; $display("FAIL lb cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            step();
        end
        load = 0;
        vecs++;
        if (!hit) begin errs++; $display("FAIL lb_timeout got no boundary want one"); end
        for (int i = 0; i < 100 && m_cnt != 2; i++) begin
            slow = ph[2];
            #1;
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv()) begin
                errs++; $display("FAIL lb_run cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            step();
        end
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        vecs++;
        if ({o_pwm, o_period_done, o_busy} !== 3'b000) begin
            errs++; $display("FAIL lb_reset got pwm/done/busy %b want 000", {o_pwm, o_period_done, o_busy});
        end
        for (int i = 0; i < 48; i++) begin
            slow = ph[2];
            #1;
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv() || o_pwm !== 1'b0) begin
                errs++; $display("FAIL lb_after cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            rst_n  = ($urandom % 300) != 0;
            if ($urandom % 40 == 0) en = ~en;
            load   = ($urandom % 15) == 0;
            period = 8'($urandom % 6);
            duty   = 8'($urandom % 8);
            if ($urandom % 3 == 0) slow = ~slow;
            #1;
            vecs++;
            if ({o_pwm, o_tick, o_period_done, o_busy} !== expv()) begin
                errs++; $display("FAIL random cyc %0d got %b want %b", i, {o_pwm, o_tick, o_period_done, o_busy}, expv());
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_duty_corners();
        test_drain();
        test_load_boundary_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
